// File: rtl/spm_dp_pkg.sv
// Shared constants for the dual-port scratch-pad: default depth, strobe/direction
// encodings and the controller state type.
package spm_dp_pkg;

    localparam int SpmDepth = 4096;

    // Strobes and ready are active-low; rw is high for a read.
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;
    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;

    typedef enum logic {
        SPM_ST_CLEAR = 1'b0,
        SPM_ST_READY = 1'b1
    } spm_state_e;

endpackage

// File: rtl/spm_dpram_core.sv
// DEPTH x DATA_W word array with two byte-enabled write ports and two registered
// read ports. Same-address write priority is resolved by the caller's byte enables.
module spm_dpram_core #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                a_we_i,
    input  logic [ADDR_W-1:0]   a_addr_i,
    input  logic [DATA_W/8-1:0] a_be_i,
    input  logic [DATA_W-1:0]   a_wd_i,
    input  logic                a_re_i,
    input  logic                a_rz_i,
    input  logic [DATA_W-1:0]   a_fmask_i,
    input  logic [DATA_W-1:0]   a_fdata_i,
    output logic [DATA_W-1:0]   a_rd_o,
    input  logic                b_we_i,
    input  logic [ADDR_W-1:0]   b_addr_i,
    input  logic [DATA_W/8-1:0] b_be_i,
    input  logic [DATA_W-1:0]   b_wd_i,
    input  logic                b_re_i,
    input  logic                b_rz_i,
    input  logic [DATA_W-1:0]   b_fmask_i,
    input  logic [DATA_W-1:0]   b_fdata_i,
    output logic [DATA_W-1:0]   b_rd_o
);

    localparam int BE_W = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] a_rd_q;
    logic [DATA_W-1:0] b_rd_q;

    always_ff @(posedge clk) begin
        for (int k = 0; k < BE_W; k++) begin
            if (a_we_i && a_be_i[k]) mem_q[a_addr_i][8*k +: 8] <= a_wd_i[8*k +: 8];
            if (b_we_i && b_be_i[k]) mem_q[b_addr_i][8*k +: 8] <= b_wd_i[8*k +: 8];
        end
    end

    // Forward masks splice the other port's same-cycle write into the captured word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rd_q <= '0;
            b_rd_q <= '0;
        end else begin
            if (a_re_i)
                a_rd_q <= a_rz_i ? '0 : ((mem_q[a_addr_i] & ~a_fmask_i) | (a_fdata_i & a_fmask_i));
            if (b_re_i)
                b_rd_q <= b_rz_i ? '0 : ((mem_q[b_addr_i] & ~b_fmask_i) | (b_fdata_i & b_fmask_i));
        end
    end

    assign a_rd_o = a_rd_q;
    assign b_rd_o = b_rd_q;

endmodule

// File: rtl/spm_dp.sv
// Dual-port scratch-pad top: clear/ready controller, range check and err pulses,
// cross-port collision resolution and write forwarding around spm_dpram_core.
module spm_dp
    import spm_dp_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int DEPTH          = SpmDepth,
    parameter int ADDR_W         = $clog2(DEPTH),
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   if_spm_addr,
    input  logic                if_spm_as_,
    input  logic                if_spm_rw,
    input  logic [DATA_W/8-1:0] if_spm_be,
    input  logic [DATA_W-1:0]   if_spm_wr_data,
    output logic [DATA_W-1:0]   if_spm_rd_data,
    output logic                if_spm_rdy_,
    output logic                if_spm_err,
    input  logic [ADDR_W-1:0]   mem_spm_addr,
    input  logic                mem_spm_as_,
    input  logic                mem_spm_rw,
    input  logic [DATA_W/8-1:0] mem_spm_be,
    input  logic [DATA_W-1:0]   mem_spm_wr_data,
    output logic [DATA_W-1:0]   mem_spm_rd_data,
    output logic                mem_spm_rdy_,
    output logic                mem_spm_err,
    output spm_state_e          dbg_state_o
);

    localparam int                BE_W     = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(DEPTH - 1);
    localparam spm_state_e        RESET_ST = (CLEAR_ON_RESET != 0) ? SPM_ST_CLEAR : SPM_ST_READY;

    spm_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              a_err_q, b_err_q;

    logic              ready, clearing;
    logic              a_acc, a_inr, a_we, a_re;
    logic              b_acc, b_inr, b_we, b_re;
    logic              same_addr;
    logic [BE_W-1:0]   a_be_c;
    logic              b_we_c;
    logic [ADDR_W-1:0] b_addr_c;
    logic [BE_W-1:0]   b_be_c;
    logic [DATA_W-1:0] b_wd_c;
    logic [DATA_W-1:0] a_be_mask, b_be_mask;
    logic [DATA_W-1:0] a_fmask, b_fmask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET_ST;
            cnt_q   <= '0;
            a_err_q <= 1'b0;
            b_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_err_q <= a_acc && !a_inr;
            b_err_q <= b_acc && !b_inr;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == SPM_ST_CLEAR) begin
            cnt_d = cnt_q + ADDR_W'(1);
            if (cnt_q == LAST) begin
                state_d = SPM_ST_READY;
                cnt_d   = '0;
            end
        end
    end

    assign ready    = (state_q == SPM_ST_READY);
    assign clearing = (state_q == SPM_ST_CLEAR);

    assign a_acc = ready && (if_spm_as_ == ENABLE_);
    assign b_acc = ready && (mem_spm_as_ == ENABLE_);
    assign a_inr = {1'b0, if_spm_addr} < DEPTH_X;
    assign b_inr = {1'b0, mem_spm_addr} < DEPTH_X;
    assign a_we  = a_acc && (if_spm_rw == WRITE) && a_inr;
    assign b_we  = b_acc && (mem_spm_rw == WRITE) && b_inr;
    assign a_re  = a_acc && (if_spm_rw == READ);
    assign b_re  = b_acc && (mem_spm_rw == READ);

    assign same_addr = (if_spm_addr == mem_spm_addr);

    for (genvar k = 0; k < BE_W; k++) begin : g_mask
        assign a_be_mask[8*k +: 8] = {8{if_spm_be[k]}};
        assign b_be_mask[8*k +: 8] = {8{mem_spm_be[k]}};
    end

    // Port B owns any byte both ports write at the same address.
    assign a_be_c  = (b_we && same_addr) ? (if_spm_be & ~mem_spm_be) : if_spm_be;
    assign a_fmask = (b_we && same_addr) ? b_be_mask : '0;
    assign b_fmask = (a_we && same_addr) ? a_be_mask : '0;

    // During CLEAR the core's port B is borrowed to zero one word per cycle.
    assign b_we_c   = clearing ? 1'b1 : b_we;
    assign b_addr_c = clearing ? cnt_q : mem_spm_addr;
    assign b_be_c   = clearing ? '1 : mem_spm_be;
    assign b_wd_c   = clearing ? '0 : mem_spm_wr_data;

    spm_dpram_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_we_i    (a_we),
        .a_addr_i  (if_spm_addr),
        .a_be_i    (a_be_c),
        .a_wd_i    (if_spm_wr_data),
        .a_re_i    (a_re),
        .a_rz_i    (!a_inr),
        .a_fmask_i (a_fmask),
        .a_fdata_i (mem_spm_wr_data),
        .a_rd_o    (if_spm_rd_data),
        .b_we_i    (b_we_c),
        .b_addr_i  (b_addr_c),
        .b_be_i    (b_be_c),
        .b_wd_i    (b_wd_c),
        .b_re_i    (b_re),
        .b_rz_i    (!b_inr),
        .b_fmask_i (b_fmask),
        .b_fdata_i (if_spm_wr_data),
        .b_rd_o    (mem_spm_rd_data)
    );

    assign if_spm_rdy_  = ready ? ENABLE_ : DISABLE_;
    assign mem_spm_rdy_ = ready ? ENABLE_ : DISABLE_;
    assign if_spm_err   = a_err_q;
    assign mem_spm_err  = b_err_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_spm_dp.sv
// Directed bench for spm_dp: a DEPTH=16 and a DEPTH=12 instance share stimulus;
// reads push expectations into queues that a negedge monitor pops and compares.
module tb_spm_dp;
    import spm_dp_pkg::*;

    localparam int DW = 32;
    localparam int BW = 4;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic          a_as = DISABLE_, b_as = DISABLE_;
    logic          a_rw = READ, b_rw = READ;
    logic [BW-1:0] a_be = '0, b_be = '0;
    logic [DW-1:0] a_wd = '0, b_wd = '0;

    logic [DW-1:0] rd_a16, rd_b16, rd_a12, rd_b12;
    logic          rdy_a16, rdy_b16, rdy_a12, rdy_b12;
    logic          err_a16, err_b16, err_a12, err_b12;
    spm_state_e    st16, st12;

    int n_cmp = 0;
    int n_fail = 0;

    logic [DW-1:0] exp_a_q[$];
    logic [DW-1:0] exp_b_q[$];
    bit            c12_q[$];
    bit            a_chk = 1'b0, b_chk = 1'b0;
    bit            a_chk_d = 1'b0, b_chk_d = 1'b0;

    spm_dp #(.DATA_W(DW), .DEPTH(16), .CLEAR_ON_RESET(1)) u_dut16 (
        .clk(clk), .rst_n(rst_n),
        .if_spm_addr(a_addr), .if_spm_as_(a_as), .if_spm_rw(a_rw), .if_spm_be(a_be),
        .if_spm_wr_data(a_wd), .if_spm_rd_data(rd_a16), .if_spm_rdy_(rdy_a16), .if_spm_err(err_a16),
        .mem_spm_addr(b_addr), .mem_spm_as_(b_as), .mem_spm_rw(b_rw), .mem_spm_be(b_be),
        .mem_spm_wr_data(b_wd), .mem_spm_rd_data(rd_b16), .mem_spm_rdy_(rdy_b16), .mem_spm_err(err_b16),
        .dbg_state_o(st16)
    );

    spm_dp #(.DATA_W(DW), .DEPTH(12), .CLEAR_ON_RESET(1)) u_dut12 (
        .clk(clk), .rst_n(rst_n),
        .if_spm_addr(a_addr), .if_spm_as_(a_as), .if_spm_rw(a_rw), .if_spm_be(a_be),
        .if_spm_wr_data(a_wd), .if_spm_rd_data(rd_a12), .if_spm_rdy_(rdy_a12), .if_spm_err(err_a12),
        .mem_spm_addr(b_addr), .mem_spm_as_(b_as), .mem_spm_rw(b_rw), .mem_spm_be(b_be),
        .mem_spm_wr_data(b_wd), .mem_spm_rd_data(rd_b12), .mem_spm_rdy_(rdy_b12), .mem_spm_err(err_b12),
        .dbg_state_o(st12)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard helpers ----------------
    function automatic void check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    always @(posedge clk) begin
        a_chk_d <= a_chk;
        b_chk_d <= b_chk;
    end

    always @(negedge clk) begin
        logic [DW-1:0] e;
        bit c12;
        if (a_chk_d) begin
            if (exp_a_q.size() == 0) begin
                check("a_queue_underflow", 32'd1, 32'd0);
            end else begin
                e = exp_a_q.pop_front();
                c12 = c12_q.pop_front();
                check("rd_a16", rd_a16, e);
                if (c12) check("rd_a12", rd_a12, e);
            end
        end
        if (b_chk_d) begin
            if (exp_b_q.size() == 0) begin
                check("b_queue_underflow", 32'd1, 32'd0);
            end else begin
                e = exp_b_q.pop_front();
                check("rd_b16", rd_b16, e);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic a_idle();
        a_as = DISABLE_; a_chk = 1'b0;
    endtask

    task automatic b_idle();
        b_as = DISABLE_; b_chk = 1'b0;
    endtask

    task automatic a_wr(input logic [AW-1:0] ad, input logic [DW-1:0] d, input logic [BW-1:0] be);
        a_as = ENABLE_; a_rw = WRITE; a_addr = ad; a_wd = d; a_be = be; a_chk = 1'b0;
    endtask

    task automatic b_wr(input logic [AW-1:0] ad, input logic [DW-1:0] d, input logic [BW-1:0] be);
        b_as = ENABLE_; b_rw = WRITE; b_addr = ad; b_wd = d; b_be = be; b_chk = 1'b0;
    endtask

    task automatic a_rd(input logic [AW-1:0] ad, input logic [DW-1:0] exp, input bit c12);
        a_as = ENABLE_; a_rw = READ; a_addr = ad; a_chk = 1'b1;
        exp_a_q.push_back(exp);
        c12_q.push_back(c12);
    endtask

    task automatic b_rd(input logic [AW-1:0] ad, input logic [DW-1:0] exp);
        b_as = ENABLE_; b_rw = READ; b_addr = ad; b_chk = 1'b1;
        exp_b_q.push_back(exp);
    endtask

    task automatic a_rd_raw(input logic [AW-1:0] ad);
        a_as = ENABLE_; a_rw = READ; a_addr = ad; a_chk = 1'b0;
    endtask

    // Counts cycles with rdy_ deasserted on each instance; optional strobes probe CLEAR.
    task automatic count_clear(output int n16, output int n12, input bit strobes);
        n16 = 0;
        n12 = 0;
        for (int i = 0; i < 40; i++) begin
            if (rdy_a16 == DISABLE_) n16++;
            if (rdy_a12 == DISABLE_) n12++;
            if (rdy_a16 == ENABLE_ && rdy_a12 == ENABLE_) break;
            a_idle();
            b_idle();
            if (strobes) begin
                if (i == 4) begin
                    a_wr(4'd0, 32'hDEADBEEF, 4'hF);
                    b_wr(4'd1, 32'hCAFEF00D, 4'hF);
                end
                if (i == 6) a_rd_raw(4'd13);
                if (i == 7) begin
                    check("clr_rd_a16", rd_a16, 32'h0);
                    check("clr_err_a12", {31'h0, err_a12}, 32'h0);
                end
            end
            tick();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n16, n12;

        tick();
        tick();
        check("rst_rd_a16", rd_a16, 32'h0);
        check("rst_rd_b16", rd_b16, 32'h0);
        check("rst_err_a16", {31'h0, err_a16}, 32'h0);
        check("rst_err_b16", {31'h0, err_b16}, 32'h0);
        check("rst_rdy_a16", {31'h0, rdy_a16}, {31'h0, DISABLE_});
        check("rst_rdy_b12", {31'h0, rdy_b12}, {31'h0, DISABLE_});

        rst_n = 1'b1;
        count_clear(n16, n12, 1'b1);
        check("clear_cycles16", n16, 32'd16);
        check("clear_cycles12", n12, 32'd12);
        check("ready_b16", {31'h0, rdy_b16}, {31'h0, ENABLE_});
        check("post_clr_rd_b16", rd_b16, 32'h0);

        // Whole array reads as zero, including the words strobed during CLEAR.
        for (int i = 0; i < 16; i++) begin
            a_rd(AW'(i), 32'h0, 1'b1);
            tick();
        end
        a_idle();
        tick();

        // Out of range on the 12-deep instance.
        b_wr(4'd11, 32'h00000077, 4'hF);
        tick();
        b_idle();
        a_rd(4'd11, 32'h00000077, 1'b1);
        tick();
        a_rd(4'd13, 32'h0, 1'b1);
        b_wr(4'd14, 32'hA5A5A5A5, 4'hF);
        tick();
        check("oor_err_a12", {31'h0, err_a12}, 32'h1);
        check("oor_err_b12", {31'h0, err_b12}, 32'h1);
        check("inr_err_a16", {31'h0, err_a16}, 32'h0);
        a_idle();
        b_idle();
        tick();
        check("oor_err_a12_drop", {31'h0, err_a12}, 32'h0);
        check("oor_err_b12_drop", {31'h0, err_b12}, 32'h0);
        for (int i = 0; i < 12; i++) begin
            a_rd(AW'(i), (i == 11) ? 32'h00000077 : 32'h0, 1'b1);
            tick();
        end
        check("inr_err_a12", {31'h0, err_a12}, 32'h0);
        a_rd(4'd14, 32'hA5A5A5A5, 1'b0);
        tick();
        a_idle();

        // Port B fills 255-i; port A reads back with idle gaps.
        for (int i = 0; i < 16; i++) begin
            b_wr(AW'(i), 32'(255 - i), 4'hF);
            tick();
        end
        b_idle();
        for (int i = 0; i < 16; i++) begin
            a_rd(AW'(i), 32'(255 - i), i < 12);
            tick();
            a_idle();
            tick();
            check("hold_rd_a16", rd_a16, 32'(255 - i));
        end

        // Byte merge and a zero-enable write.
        b_wr(4'd5, 32'h11223344, 4'hF);
        tick();
        b_wr(4'd5, 32'hAABBCCDD, 4'b0101);
        tick();
        b_idle();
        a_rd(4'd5, 32'h11BB33DD, 1'b1);
        tick();
        a_wr(4'd5, 32'hFFFFFFFF, 4'h0);
        tick();
        a_rd(4'd5, 32'h11BB33DD, 1'b1);
        tick();

        // Same-cycle collisions at address 3.
        a_idle();
        b_wr(4'd3, 32'h0, 4'hF);
        tick();
        a_wr(4'd3, 32'hFFFF0000, 4'hF);
        b_wr(4'd3, 32'h0000BEEF, 4'h3);
        tick();
        b_idle();
        a_rd(4'd3, 32'hFFFFBEEF, 1'b1);
        tick();
        a_rd(4'd3, 32'h12345678, 1'b1);
        b_wr(4'd3, 32'h12345678, 4'hF);
        tick();
        a_rd(4'd3, 32'hAA3456DD, 1'b1);
        b_wr(4'd3, 32'hAABBCCDD, 4'b1001);
        tick();
        a_wr(4'd3, 32'h00000011, 4'b0001);
        b_rd(4'd3, 32'hAA345611);
        tick();
        a_rd(4'd3, 32'hAA345611, 1'b1);
        b_rd(4'd3, 32'hAA345611);
        tick();
        a_wr(4'd7, 32'h01010101, 4'hF);
        b_wr(4'd7, 32'h02020202, 4'hF);
        tick();
        b_idle();
        a_rd(4'd7, 32'h02020202, 1'b1);
        tick();
        a_idle();
        tick();

        // Reset at clear count 7 restarts the sweep.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        check("mid_clear_state", {31'h0, st16}, {31'h0, SPM_ST_CLEAR});
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        count_clear(n16, n12, 1'b0);
        check("restart_cycles16", n16, 32'd16);
        check("restart_cycles12", n12, 32'd12);
        check("restart_state16", {31'h0, st16}, {31'h0, SPM_ST_READY});
        a_rd(4'd15, 32'h0, 1'b0);
        tick();
        a_rd(4'd3, 32'h0, 1'b1);
        tick();
        a_idle();
        b_idle();
        tick();
        tick();

        check("a_queue_drained", exp_a_q.size(), 32'd0);
        check("b_queue_drained", exp_b_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "timeout");
    end

endmodule
